// File: rtl/elm_output_scheduler_if.sv
// Handshake/bus bundle between the ELM output scheduler and its environment
// (start control, shared accumulator, memory addresses, result reporting).
interface elm_output_scheduler_if #(
    parameter int HA_W  = 6,
    parameter int CA_W  = 4,
    parameter int WA_W  = 10,
    parameter int ACC_W = 32
);
    logic             start;
    logic [ACC_W-1:0] acc_val;
    logic [HA_W-1:0]  h_addr;
    logic [WA_W-1:0]  w_addr;
    logic             acc_rst;
    logic             acc_load;
    logic             busy;
    logic             done;
    logic [CA_W-1:0]  class_id;
    logic [ACC_W-1:0] max_val;

    modport master (
        input  start, acc_val,
        output h_addr, w_addr, acc_rst, acc_load, busy, done, class_id, max_val
    );

    modport slave (
        output start, acc_val,
        input  h_addr, w_addr, acc_rst, acc_load, busy, done, class_id, max_val
    );
endinterface

// File: rtl/elm_output_scheduler.sv
// ELM output-layer sequencer: per class, streams hidden/beta addresses into the
// shared accumulator, then folds the class score into a running signed argmax.
module elm_output_scheduler #(
    parameter int N_HIDDEN = 64,
    parameter int N_CLASS  = 10,
    parameter int HA_W     = 6,
    parameter int CA_W     = 4,
    parameter int WA_W     = 10,
    parameter int ACC_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    elm_output_scheduler_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_DRAIN,
        S_WAIT,
        S_COMPARE,
        S_FINISH
    } state_e;

    localparam logic [HA_W-1:0] H_LAST  = HA_W'(N_HIDDEN - 1);
    localparam logic [CA_W-1:0] C_LAST  = CA_W'(N_CLASS - 1);
    localparam logic [WA_W-1:0] W_ROW   = WA_W'(N_HIDDEN);

    state_e            state_q, state_d;
    logic [HA_W-1:0]   h_q, h_d;
    logic [CA_W-1:0]   c_q, c_d;
    logic [WA_W-1:0]   base_q, base_d;
    logic [HA_W-1:0]   h_addr_q, h_addr_d;
    logic [WA_W-1:0]   w_addr_q, w_addr_d;
    logic              load_q, load_d;
    logic [CA_W-1:0]   cls_q, cls_d;
    logic [ACC_W-1:0]  max_q, max_d;

    logic              addr_vld;
    logic              acc_rst_c;
    logic              done_c;
    logic [HA_W-1:0]   h_addr_c;
    logic [WA_W-1:0]   w_addr_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            h_q      <= '0;
            c_q      <= '0;
            base_q   <= '0;
            h_addr_q <= '0;
            w_addr_q <= '0;
            load_q   <= 1'b0;
            cls_q    <= '0;
            max_q    <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            c_q      <= c_d;
            base_q   <= base_d;
            h_addr_q <= h_addr_d;
            w_addr_q <= w_addr_d;
            load_q   <= load_d;
            cls_q    <= cls_d;
            max_q    <= max_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        c_d       = c_q;
        base_d    = base_q;
        cls_d     = cls_q;
        max_d     = max_q;
        h_addr_c  = h_addr_q;
        w_addr_c  = w_addr_q;
        addr_vld  = 1'b0;
        acc_rst_c = 1'b1;
        done_c    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                h_d     = '0;
                c_d     = '0;
                base_d  = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                // Row base tracks c*N_HIDDEN incrementally, so no multiplier
                // and no intermediate wider than WA_W is needed.
                acc_rst_c = 1'b0;
                addr_vld  = 1'b1;
                h_addr_c  = h_q;
                w_addr_c  = base_q + WA_W'(h_q);
                if (h_q == H_LAST) begin
                    h_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            S_DRAIN: begin
                acc_rst_c = 1'b0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                acc_rst_c = 1'b0;
                state_d   = S_COMPARE;
            end
            S_COMPARE: begin
                // Strict compare: an equal later score never displaces the
                // earlier class.
                if (c_q == '0 || $signed(bus.acc_val) > $signed(max_q)) begin
                    max_d = bus.acc_val;
                    cls_d = c_q;
                end
                if (c_q == C_LAST) begin
                    state_d = S_FINISH;
                end else begin
                    c_d     = c_q + 1'b1;
                    base_d  = base_q + W_ROW;
                    state_d = S_MAC;
                end
            end
            S_FINISH: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        h_addr_d = h_addr_c;
        w_addr_d = w_addr_c;
        // Memory data arrives one cycle after its address.
        load_d   = addr_vld;
    end

    assign bus.h_addr   = h_addr_c;
    assign bus.w_addr   = w_addr_c;
    assign bus.acc_rst  = acc_rst_c;
    assign bus.acc_load = load_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_c;
    assign bus.class_id = cls_q;
    assign bus.max_val  = max_q;

endmodule
